complex_mult_pipe: RTL
======================

Name: complex_mult_pipe

Overview:
- Pipelined complex multiplier for the FFT datapath: computes Y = A × W, with A a complex sample and W a complex twiddle factor.
- Sits directly upstream of the complex adder stage. Output uses the same packed {re, im} signed format the adder consumes.
- Streaming valid/ready handshake on both sides; global stall on output backpressure.
- Rounds and rescales Q-format products back to the 11-bit sample width.

Parameters:
- DW, 11, signed width of each real/imag sample component.
- TW, 11, signed width of each real/imag twiddle component.
- TW_FRAC, 9, twiddle fraction bits (1.0 = 512).
- OVF_W, 8, width of the overflow event counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  A/W present this cycle.
- in_ready  out  1  block accepts A/W this cycle.
- a_in  in  2*DW  sample, {AR[DW-1:0], AI[DW-1:0]}, two's complement.
- w_in  in  2*TW  twiddle, {WR, WI}, two's complement, Q1.TW_FRAC.
- out_valid  out  1  y_out holds a result.
- out_ready  in  1  downstream accepts y_out this cycle.
- y_out  out  2*DW  product, {YR, YI}.
- ovf_cnt  out  OVF_W  count of saturated/wrapped result components.

Behaviour:
- Reset (rst_n=0 at an edge):
  - All stage valid bits, out_valid, y_out and ovf_cnt go to 0.
  - in_ready is forced 0 while rst_n=0.
  - Reset mid-stream discards all in-flight data; no partial outputs appear afterwards.
- Pipeline: three register stages S1/S2/S3.
  - S1 registers A and W.
  - S2 registers four full products: AR*WR, AI*WI, AR*WI, AI*WR (DW+TW bits each).
  - S3 forms the sums, rounds, limits and registers y_out.
- Stall rule: advance = ~out_valid | out_ready.
  - in_ready = advance (and rst_n).
  - When advance=0 every stage holds its data and valid bit.
  - When advance=1 all stages shift; bubbles propagate as valid=0.
- Latency: a transfer accepted at edge N (in_valid & in_ready) appears on y_out with out_valid=1 after edge N+2, given no stall. Throughput is 1 sample/clk.
- Output handshake:
  - Result is consumed at an edge where out_valid & out_ready.
  - y_out and out_valid stay stable while out_valid=1 and out_ready=0.
  - in_valid=0 with out_ready=1 drains the pipeline.
- Arithmetic:
  - SR = AR*WR − AI*WI and SI = AR*WI + AI*WR, computed at DW+TW+1 bits. No intermediate overflow is allowed.
  - Rounding is round-half-up: R = (S + 2^(TW_FRAC−1)) >>> TW_FRAC (arithmetic shift).
  - Range limit to DW bits: see the optional feature below. Each component whose R lies outside [−2^(DW−1), 2^(DW−1)−1] is one overflow event.
- ovf_cnt:
  - Increments by the number of overflow events (0, 1 or 2) in the S3 result, only when S3 loads a valid result.
  - Saturates at 2^OVF_W−1; never wraps. Cleared only by reset.
- Simultaneous accept and consume in the same cycle is legal and required for full throughput.

Optional Feature:
- Macro: CMUL_SAT_EN.
- Defined: each out-of-range component clamps to +1023 or −1024 (for DW=11).
- Undefined: each component is truncated to its low DW bits (two's-complement wrap).
- ovf_cnt counts the events in both builds.

Test Plan:
- Identity: A=(100,0), W=(512,0), out_ready=1 → after edge N+2, y_out=(100,0), ovf_cnt=0.
- Rotate by j: A=(100,50), W=(0,512) → (−50,100). Then W=(0,−512) back-to-back next cycle → (50,−100) one cycle later.
- Rounding, each with W=(256,0):
  - A=(1,0) → YR=1.
  - A=(−1,0) → YR=0.
  - A=(3,−3) → (2,−1).
- Overflow: A=(−1024,−1024), W=(−512,−512) → YR=0.
  - With CMUL_SAT_EN: YI=1023.
  - Without: YI=0.
  - ovf_cnt=1 in both builds.
- Backpressure: stream 5 samples, hold out_ready=0 for 4 cycles mid-stream.
  - in_ready drops once out_valid=1.
  - y_out is stable throughout the stall.
  - All 5 results arrive in order with no loss or duplication.
- Reset mid-stream: assert rst_n=0 for 1 cycle with 3 samples in flight → out_valid=0, y_out=0, ovf_cnt=0, and no stale outputs afterwards.

Source files
------------

// File: rtl/complex_mult_pipe.sv
// rtl/complex_mult_pipe.sv - 3-stage pipelined complex multiplier Y = A*W with round, range limit and overflow count
// Build option: define CMUL_SAT_EN to saturate out-of-range components (default wraps).
module complex_mult_pipe #(
    parameter int DW      = 11,
    parameter int TW      = 11,
    parameter int TW_FRAC = 9,
    parameter int OVF_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*DW-1:0]     a_in,
    input  logic [2*TW-1:0]     w_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DW-1:0]     y_out,
    output logic [OVF_W-1:0]    ovf_cnt
);

    localparam int PW = DW + TW;
    localparam int SW = PW + 1;
    localparam logic signed [SW-1:0] RND = SW'(2 ** (TW_FRAC - 1));

    logic advance;

    logic                 s1_valid;
    logic signed [DW-1:0] s1_ar, s1_ai;
    logic signed [TW-1:0] s1_wr, s1_wi;

    logic signed [PW-1:0] ar_x, ai_x, wr_x, wi_x;

    logic                 s2_valid;
    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;

    logic signed [SW-1:0] sr, si, r_r, r_i;
    logic                 ovf_r, ovf_i;
    logic [DW-1:0]        y_r, y_i;
    logic [1:0]           ovf_inc;
    logic [OVF_W:0]       cnt_sum;

    // Single global stall: everything moves only when the output slot is free or draining.
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_ar    <= '0;
            s1_ai    <= '0;
            s1_wr    <= '0;
            s1_wi    <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_ar <= a_in[2*DW-1:DW];
                s1_ai <= a_in[DW-1:0];
                s1_wr <= w_in[2*TW-1:TW];
                s1_wi <= w_in[TW-1:0];
            end
        end
    end

    assign ar_x = PW'(s1_ar);
    assign ai_x = PW'(s1_ai);
    assign wr_x = PW'(s1_wr);
    assign wi_x = PW'(s1_wi);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            p_rr     <= '0;
            p_ii     <= '0;
            p_ri     <= '0;
            p_ir     <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                p_rr <= ar_x * wr_x;
                p_ii <= ai_x * wi_x;
                p_ri <= ar_x * wi_x;
                p_ir <= ai_x * wr_x;
            end
        end
    end

    // One extra bit on the sums keeps AR*WR - AI*WI exact even at the most negative corner.
    always_comb begin
        sr      = {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii};
        si      = {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir};
        r_r     = (sr + RND) >>> TW_FRAC;
        r_i     = (si + RND) >>> TW_FRAC;
        ovf_r   = ~(&r_r[SW-1:DW-1]) & (|r_r[SW-1:DW-1]);
        ovf_i   = ~(&r_i[SW-1:DW-1]) & (|r_i[SW-1:DW-1]);
`ifdef CMUL_SAT_EN
        y_r     = ovf_r ? {r_r[SW-1], {(DW-1){~r_r[SW-1]}}} : r_r[DW-1:0];
        y_i     = ovf_i ? {r_i[SW-1], {(DW-1){~r_i[SW-1]}}} : r_i[DW-1:0];
`else
        y_r     = r_r[DW-1:0];
        y_i     = r_i[DW-1:0];
`endif
        ovf_inc = {1'b0, ovf_r} + {1'b0, ovf_i};
        cnt_sum = {1'b0, ovf_cnt} + {{(OVF_W-1){1'b0}}, ovf_inc};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y_out     <= '0;
            ovf_cnt   <= '0;
        end else if (advance) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                y_out   <= {y_r, y_i};
                ovf_cnt <= cnt_sum[OVF_W] ? {OVF_W{1'b1}} : cnt_sum[OVF_W-1:0];
            end
        end
    end

endmodule
